// File: rtl/bram_frame_pkg.sv
// Shared types for the LLR BRAM frame controller: FSM state encoding and skid FIFO depth.
package bram_frame_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, READ, DONE} state_t;
   localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/bram_frame_skid.sv
// Two-entry skid FIFO holding {q1, q2, last} readback words ahead of the output handshake.
// Head is combinational from storage; a push while full is accepted only together with a pop.
module bram_frame_skid
   import bram_frame_pkg::*;
#(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [1:0]   count,
   output logic         full,
   output logic         empty
);

   logic [W-1:0] mem [FIFO_DEPTH];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         wr_en;
   logic         rd_en;

   assign full  = (count == 2'(FIFO_DEPTH));
   assign empty = (count == 2'd0);
   assign head  = mem[rd_ptr];
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (rd_en) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + 2'(wr_en) - 2'(rd_en);
      end
   end

endmodule

// File: rtl/bram_frame_ctrl.sv
// Loads one LLR frame into the BRAM from a valid/ready stream, then sweeps it back out on a second stream.
// Optional sticky protocol-error output when BRAM_FRAME_CTRL_ERR_EN is defined.
module bram_frame_ctrl
   import bram_frame_pkg::*;
#(
   parameter int DW    = 8,
   parameter int AW    = 4,
   parameter int DEPTH = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] bram_data_in,
   output logic [AW-1:0] bram_addr,
   output logic          bram_write,
   input  logic [DW-1:0] bram_q1,
   input  logic [DW-1:0] bram_q2,
   output logic [DW-1:0] out_data1,
   output logic [DW-1:0] out_data2,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   output logic          frame_done
`ifdef BRAM_FRAME_CTRL_ERR_EN
   ,
   output logic          err
`endif
);

   localparam int            FW   = 2 * DW + 1;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          rd_done;
   logic          inflight;
   logic          inflight_last;
   logic          beat;
   logic          issue;
   logic          pop;
   logic [2:0]    occ;
   logic [FW-1:0] head;
   logic [1:0]    count;
   logic          full;
   logic          empty;

   assign beat = in_valid && (state == LOAD);
   assign pop  = out_valid && out_ready;
   // A same-cycle pop frees its slot, which keeps the sweep at one beat per cycle.
   assign occ  = 3'(count) + 3'(inflight) - 3'(pop);

   always_comb begin
      state_nxt    = state;
      in_ready     = 1'b0;
      bram_write   = 1'b0;
      bram_data_in = '0;
      bram_addr    = wptr;
      issue        = 1'b0;
      case (state)
         IDLE: state_nxt = LOAD;
         LOAD: begin
            in_ready = 1'b1;
            if (beat) begin
               bram_write   = 1'b1;
               bram_data_in = in_data;
               if (wptr == LAST) begin
                  state_nxt = READ;
               end
            end
         end
         READ: begin
            bram_addr = rptr;
            issue     = !rd_done && (occ < 3'(FIFO_DEPTH));
            if (pop && head[0]) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = LOAD;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         wptr          <= '0;
         rptr          <= '0;
         rd_done       <= 1'b0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         state         <= state_nxt;
         inflight      <= issue;
         inflight_last <= issue && (rptr == LAST);
         if (beat) begin
            if (wptr == LAST) begin
               wptr    <= '0;
               rptr    <= '0;
               rd_done <= 1'b0;
            end else begin
               wptr <= wptr + 1'b1;
            end
         end
         if (issue) begin
            if (rptr == LAST) begin
               rd_done <= 1'b1;
            end else begin
               rptr <= rptr + 1'b1;
            end
         end
         if (state == DONE) begin
            wptr    <= '0;
            rptr    <= '0;
            rd_done <= 1'b0;
         end
      end
   end

   bram_frame_skid #(.W(FW)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .push      (inflight),
      .push_data ({bram_q1, bram_q2, inflight_last}),
      .pop       (pop),
      .head      (head),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   assign out_valid  = !empty;
   assign out_last   = out_valid && head[0];
   assign out_data1  = out_valid ? head[FW-1:DW+1] : '0;
   assign out_data2  = out_valid ? head[DW:1] : '0;
   assign frame_done = (state == DONE);

   skid_no_overflow: assert property (@(posedge clk) disable iff (!reset) inflight |-> (!full || pop));

`ifdef BRAM_FRAME_CTRL_ERR_EN
   logic err_set;
   assign err_set = (in_valid && (state == READ || state == DONE))
                 || (out_ready && !out_valid && state == READ);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err <= 1'b0;
      end else if (err_set) begin
         err <= 1'b1;
      end
   end
`endif

endmodule
